// File: rtl/avl_arbiter_pkg.sv
// Shared types for the two-port Avalon-MM arbiter.
// Holds the port id, the outstanding-read tag word and the command FSM states.
// TAG_SIZE_WIDTH must equal the arbiter's SIZE_WIDTH parameter.
package avl_arbiter_pkg;

  localparam int TAG_SIZE_WIDTH = 7;

  typedef logic port_id_t;

  // One entry per accepted read: who asked, and how many beats are still due.
  typedef struct packed {
    port_id_t                  port;
    logic [TAG_SIZE_WIDTH-1:0] beats;
  } read_tag_t;

  typedef enum logic {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/avl_arbiter_read_tag_fifo.sv
// Outstanding-read tag FIFO: synchronous, DEPTH entries, pointer-based.
// Ports: push_i/push_dat_i enqueue, pop_i dequeues, head_we_i/head_dat_i rewrite
//        the head entry in place, head_o/full_o/empty_o report status.
module read_tag_fifo
  import avl_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  read_tag_t push_dat_i,
  input  logic      pop_i,
  input  logic      head_we_i,
  input  read_tag_t head_dat_i,
  output read_tag_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  read_tag_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Head rewrite and push never target the same slot: a head exists only when
  // non-empty, and equal indices while non-empty means full, which blocks push.
  always_ff @(posedge clk) begin
    if (head_we_i && !empty_o) mem_q[rd_ptr_q[AW-1:0]] <= head_dat_i;
    if (push_i && !full_o)     mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/avl_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM port between requesters r0 and r1,
// with write bursts locked to their owner and in-order read return via tag FIFO.
// Ports: rN_* requester commands/data, avl_* controller side, err_orphan_rdata sticky.
module avl_arbiter
  import avl_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 24,
  parameter int SIZE_WIDTH      = 7,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    r0_read_req,
  input  logic                    r0_write_req,
  input  logic                    r0_burstbegin,
  input  logic [ADDR_WIDTH-1:0]   r0_addr,
  input  logic [SIZE_WIDTH-1:0]   r0_size,
  input  logic [DATA_WIDTH-1:0]   r0_wdata,
  input  logic [DATA_WIDTH/8-1:0] r0_be,
  output logic                    r0_ready,
  output logic                    r0_rdata_valid,
  output logic [DATA_WIDTH-1:0]   r0_rdata,
  input  logic                    r1_read_req,
  input  logic                    r1_write_req,
  input  logic                    r1_burstbegin,
  input  logic [ADDR_WIDTH-1:0]   r1_addr,
  input  logic [SIZE_WIDTH-1:0]   r1_size,
  input  logic [DATA_WIDTH-1:0]   r1_wdata,
  input  logic [DATA_WIDTH/8-1:0] r1_be,
  output logic                    r1_ready,
  output logic                    r1_rdata_valid,
  output logic [DATA_WIDTH-1:0]   r1_rdata,
  input  logic                    avl_ready,
  input  logic                    avl_rdata_valid,
  input  logic [DATA_WIDTH-1:0]   avl_rdata,
  output logic                    avl_read_req,
  output logic                    avl_write_req,
  output logic                    avl_burstbegin,
  output logic [ADDR_WIDTH-1:0]   avl_addr,
  output logic [SIZE_WIDTH-1:0]   avl_size,
  output logic [DATA_WIDTH-1:0]   avl_wdata,
  output logic [DATA_WIDTH/8-1:0] avl_be,
  output logic                    err_orphan_rdata
);

  arb_state_t            state_q, state_d;
  port_id_t              prio_q, prio_d;
  port_id_t              owner_q, owner_d;
  logic [SIZE_WIDTH-1:0] beats_left_q, beats_left_d;
  logic                  err_q, err_d;

  logic                  tag_full, tag_empty, tag_push, tag_pop, tag_head_we, rd_hit;
  read_tag_t             tag_head, tag_head_nxt, tag_push_dat;

  logic                  elig0, elig1, gnt_vld, rd_acc, wr_acc;
  port_id_t              gnt;
  logic                  sel_rd, sel_wr;
  logic [SIZE_WIDTH-1:0] sel_size, eff_size;

  // A read is only eligible when its tag has somewhere to go.
  assign elig0 = r0_write_req || (r0_read_req && !tag_full);
  assign elig1 = r1_write_req || (r1_read_req && !tag_full);

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    if (state_q == WBURST) begin
      gnt_vld = 1'b1;
      gnt     = owner_q;
    end else if (elig0 && elig1) begin
      gnt_vld = 1'b1;
      gnt     = prio_q;
    end else if (elig1) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
    end else if (elig0) begin
      gnt_vld = 1'b1;
    end
  end

  // Field mux defaults to port 0 when nobody is granted.
  assign sel_rd         = gnt ? r1_read_req   : r0_read_req;
  assign sel_wr         = gnt ? r1_write_req  : r0_write_req;
  assign sel_size       = gnt ? r1_size       : r0_size;
  assign avl_burstbegin = gnt_vld && (gnt ? r1_burstbegin : r0_burstbegin);
  assign avl_addr       = gnt ? r1_addr       : r0_addr;
  assign avl_size       = sel_size;
  assign avl_wdata      = gnt ? r1_wdata      : r0_wdata;
  assign avl_be         = gnt ? r1_be         : r0_be;

  // Write wins if a port strobes both; reads never slip into a locked burst.
  assign avl_write_req = gnt_vld && sel_wr;
  assign avl_read_req  = gnt_vld && sel_rd && !sel_wr && !tag_full && (state_q == IDLE);

  assign r0_ready = gnt_vld && (gnt == 1'b0) && avl_ready;
  assign r1_ready = gnt_vld && (gnt == 1'b1) && avl_ready;

  assign rd_acc   = avl_read_req  && avl_ready;
  assign wr_acc   = avl_write_req && avl_ready;
  assign eff_size = (sel_size == '0) ? SIZE_WIDTH'(1) : sel_size;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) prio_d = ~gnt;
        if (wr_acc) begin
          if (eff_size > SIZE_WIDTH'(1)) begin
            owner_d      = gnt;
            beats_left_d = eff_size - SIZE_WIDTH'(1);
            state_d      = WBURST;
          end else begin
            prio_d = ~gnt;
          end
        end
      end
      WBURST: begin
        if (wr_acc) begin
          beats_left_d = beats_left_q - SIZE_WIDTH'(1);
          if (beats_left_q == SIZE_WIDTH'(1)) begin
            prio_d  = ~owner_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return: the head tag steers each beat; pop once its last beat lands.
  assign rd_hit         = avl_rdata_valid && !tag_empty;
  assign tag_pop        = rd_hit && (tag_head.beats <= TAG_SIZE_WIDTH'(1));
  assign tag_head_we    = rd_hit && !tag_pop;
  assign r0_rdata_valid = rd_hit && (tag_head.port == 1'b0);
  assign r1_rdata_valid = rd_hit && (tag_head.port == 1'b1);
  assign r0_rdata       = avl_rdata;
  assign r1_rdata       = avl_rdata;
  assign tag_push       = rd_acc;

  always_comb begin
    tag_push_dat.port  = gnt;
    tag_push_dat.beats = TAG_SIZE_WIDTH'(eff_size);
    tag_head_nxt       = tag_head;
    tag_head_nxt.beats = tag_head.beats - TAG_SIZE_WIDTH'(1);
  end

  assign err_d            = err_q || (avl_rdata_valid && tag_empty);
  assign err_orphan_rdata = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      beats_left_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      err_q        <= err_d;
    end
  end

  read_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (tag_push),
    .push_dat_i(tag_push_dat),
    .pop_i     (tag_pop),
    .head_we_i (tag_head_we),
    .head_dat_i(tag_head_nxt),
    .head_o    (tag_head),
    .full_o    (tag_full),
    .empty_o   (tag_empty)
  );

endmodule

// File: doc/avl_arbiter.md
# avl_arbiter

Two-requester arbiter that shares the single Avalon-MM port of `ddr3_controller` between the CPU-side memory master (port 0) and a second bus master such as a display scanout or DMA engine (port 1). It sits between the requesters and `ddr3_controller`, in the `clk` (afi_clk) domain. Command arbitration is round-robin, and write bursts are locked to one owner for their full length. Read data is returned in order, routed by a FIFO of outstanding-read tags.

## Interface
Parameters:
- `DATA_WIDTH`, 64: data beat width.
- `ADDR_WIDTH`, 24: beat address width.
- `SIZE_WIDTH`, 7: burst-size field width.
- `MAX_OUTSTANDING`, 8: tag FIFO depth. Must be a power of two, 2 or greater.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, driven by afi_clk.
- `reset` in 1: async active-high reset.
- `rN_read_req`, `rN_write_req` in 1 each: requester N (N = 0, 1) command strobes.
- `rN_burstbegin` in 1: first beat of a requester burst.
- `rN_addr` in ADDR_WIDTH, `rN_size` in SIZE_WIDTH: command address and beat count.
- `rN_wdata` in DATA_WIDTH, `rN_be` in DATA_WIDTH/8: write beat and byte enables.
- `rN_ready` out 1: command/beat accepted this cycle when high together with a strobe.
- `rN_rdata_valid` out 1: read beat for requester N.
- `rN_rdata` out DATA_WIDTH: read data, `avl_rdata` broadcast to both ports.
- `avl_ready` in 1, `avl_rdata_valid` in 1, `avl_rdata` in DATA_WIDTH: controller side.
- `avl_read_req`, `avl_write_req`, `avl_burstbegin` out 1: controller command strobes.
- `avl_addr` out ADDR_WIDTH, `avl_size` out SIZE_WIDTH: controller address and beat count.
- `avl_wdata` out DATA_WIDTH, `avl_be` out DATA_WIDTH/8: controller write beat and byte enables.
- `err_orphan_rdata` out 1: sticky flag, set on read data arriving with no outstanding tag.

## Operation
- Eligibility: a requester is eligible if it asserts `write_req`, or if it asserts `read_req` while the tag FIFO is not full.
- State `IDLE`:
  - Grant goes combinationally to the eligible requester. If both are eligible, grant goes to the one indicated by the `prio` register.
  - The granted requester's command fields are muxed onto `avl_*`. The ungranted requester's `ready` is 0.
  - Granted `ready` = `avl_ready`.
- Accept: a strobe and `avl_ready` in the same cycle.
  - Read accepted: push tag {port, size} into the FIFO. `prio` moves to the other port. Stay in `IDLE`.
  - Write accepted with size ≤ 1: `prio` moves to the other port. Stay in `IDLE`.
  - Write accepted with size > 1: latch the owner and load `beats_left = size-1`. Go to `WBURST`.
- State `WBURST`:
  - Only the owner is muxed to `avl_*`. The other requester's `ready` is 0.
  - Each accepted beat decrements `beats_left`.
  - On the beat where `beats_left` = 1 is accepted: `prio` moves to the non-owner, then go to `IDLE`.
- Size 0 is treated as size 1 for both reads and writes.
- Read return: on `avl_rdata_valid`, the head tag's port gets `rN_rdata_valid` = 1 in the same cycle, and the head beat count decrements. When the count reaches 0, the tag is popped.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- `avl_rdata_valid` with an empty FIFO: the beat is dropped, neither `rN_rdata_valid` asserts, and `err_orphan_rdata` is set. It clears only on reset.
- `avl_*` strobes are 0 when no requester is granted. Field outputs are don't-care then, but are driven from port 0.

## Timing
- Command path is zero-latency combinational mux: `rN_*` → `avl_*`, and `avl_ready` → `rN_ready`.
- Read-data path is zero-latency combinational: `avl_rdata_valid` → `rN_rdata_valid`.
- Tag FIFO, `prio`, state, owner and `beats_left` update on `posedge clk`.
- Reset values:
  - State `IDLE`, `prio` = port 0, FIFO empty, `beats_left` = 0, `err_orphan_rdata` = 0.
  - All strobe outputs, `rN_ready` and `rN_rdata_valid` are 0 while no requests are present.
- Reset asserted mid-burst or with reads outstanding: all state clears immediately, including outstanding tags. The controller must be reset alongside.
- A FIFO-full read is held off and does not block the other port's eligible write.

## Structure
- Package `avl_arbiter_pkg` holds:
  - `port_id_t` (1 bit).
  - `read_tag_t` struct {`port_id_t port`; `logic [SIZE_WIDTH-1:0] beats`}.
  - State enum {`IDLE`, `WBURST`}.
- Sub-module `read_tag_fifo`: synchronous FIFO, MAX_OUTSTANDING deep.
  - Outputs full/empty, with push/pop allowed in the same cycle.
  - Head word is writable, for the beat decrement.

## Test plan
- Single requester read: r0 reads addr 0x10, size 4, `avl_ready` = 1. Expect 1 accept, a tag pushed, then 4 `avl_rdata_valid` beats all on `r0_rdata_valid` with `r1_rdata_valid` = 0, and the FIFO empty after the 4th beat.
- Contention: r0 and r1 both issue continuous size-1 reads. Expect grants alternating 0, 1, 0, 1 from reset, and return routing that matches issue order.
- Write lock: r0 writes size 8 while r1 asserts a read from cycle 2. Expect r1 `ready` = 0 for all 8 r0 beats, and r1 granted on the cycle after the 8th beat.
- FIFO full: issue 8 r1 reads with data withheld; r1's 9th read is stalled while r0's write is accepted. One returned beat of a size-1 tag unblocks r1.
- Backpressure: `avl_ready` is low for 5 cycles mid-burst. Expect no `beats_left` decrement and the grant held.
- Orphan and reset: `avl_rdata_valid` with an empty FIFO sets `err_orphan_rdata`. A reset pulse mid-burst returns `IDLE`, `prio` = 0 and the flag cleared.
